i2d_pctl: RTL
=============

I2D_PCTL -- requirements
Module: i2d_pctl

Interface
REQ-001 SHALL have port clk  in  1  single core clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-low (rst==0 resets).
REQ-003 SHALL have port id_rf_ra  in  6  register A index of instruction in ID.
REQ-004 SHALL have port id_rf_rb  in  6  register B index of instruction in ID.
REQ-005 SHALL have port id_rf_r  in  1  ID instruction reads register operands.
REQ-006 SHALL have port ex_load  in  1  instruction in EX is a load.
REQ-007 SHALL have port ex_rd  in  6  destination register of EX instruction.
REQ-008 SHALL have port ex_br_taken  in  1  branch in EX resolved taken.
REQ-009 SHALL have port id_swi  in  1  ID instruction is SWI.
REQ-010 SHALL have port id_err  in  1  ID decode error (illegal opcode).
REQ-011 SHALL have port md_start  in  1  multi-cycle MUL/DIV issued to EX this cycle.
REQ-012 SHALL have port md_done  in  1  MUL/DIV result valid.
REQ-013 SHALL have port if_stall  out  1  hold PC and IF/ID register.
REQ-014 SHALL have port id_dis  out  1  inject bubble into ID (drives ID stage disable).
REQ-015 SHALL have port flush  out  1  invalidate IF and ID contents.
REQ-016 SHALL have port pc_sel  out  2  00 sequential, 01 branch target, 10 exception vector, 11 unused.
REQ-017 SHALL have port exc_cause  out  2  registered: 0 none, 1 SWI, 2 illegal, 3 MUL/DIV timeout.
REQ-018 SHALL have port md_busy  out  1  MUL/DIV wait in progress.

Function
REQ-019 SHALL implement states RUN, MD_WAIT, EXC, FLUSH; state and md_cnt (6-bit) registered, other outputs combinational from state and inputs.
REQ-020 SHALL, in RUN, evaluate events with priority: exception (id_swi|id_err) > ex_br_taken > md_start > load-use.
REQ-021 SHALL on exception in RUN: next state EXC, exc_cause <= 2 if id_err else 1 (id_err wins if both).
REQ-022 SHALL in EXC assert pc_sel=10, flush=1, id_dis=1 for exactly one cycle, then go to FLUSH.
REQ-023 SHALL on ex_br_taken in RUN: pc_sel=01 same cycle, next state FLUSH.
REQ-024 SHALL in FLUSH assert flush=1, id_dis=1 for one cycle, ignore all event inputs, then go to RUN.
REQ-025 SHALL on md_start in RUN: next state MD_WAIT, md_cnt <= 0.
REQ-026 SHALL in MD_WAIT assert if_stall=1, id_dis=1, md_busy=1, increment md_cnt each cycle, ignore ex_br_taken, id_swi, id_err.
REQ-027 SHALL leave MD_WAIT to RUN on cycle md_done=1 is sampled; md_busy drops the next cycle.
REQ-028 SHALL, if md_cnt reaches 32 with md_done=0, go to EXC with exc_cause <= 3; md_done on that same cycle wins (to RUN).
REQ-029 SHALL in RUN with no higher event, assert if_stall=1 and id_dis=1 for the cycle when ex_load & id_rf_r & ex_rd!=0 & (ex_rd==id_rf_ra | ex_rd==id_rf_rb); state stays RUN.
REQ-030 SHALL hold exc_cause until the next exception is taken; SHALL drive all outputs 0 in RUN with no event.

Reset
REQ-031 SHALL on rst==0, asynchronously: state RUN, md_cnt 0, exc_cause 0, all outputs 0, regardless of state (incl. mid MD_WAIT).
REQ-032 SHALL resume normal evaluation the first rising clk edge after rst returns 1.

Verification
REQ-033 Load-use: ex_load=1, ex_rd=5, id_rf_r=1, id_rf_ra=5 -> if_stall=id_dis=1 one cycle; repeat with ex_rd=0 -> no stall.
REQ-034 Branch: ex_br_taken=1 in RUN -> pc_sel=01 that cycle, flush=id_dis=1 next cycle, RUN after.
REQ-035 Exception: id_swi=1 & id_err=1 -> EXC (pc_sel=10, flush=1), exc_cause=2, FLUSH, RUN; exc_cause stays 2.
REQ-036 MUL/DIV: md_start, md_done 7 cycles later -> if_stall/md_busy high 7 cycles, then 0; ex_br_taken pulse during wait ignored.
REQ-037 Timeout: md_start, md_done never -> EXC after md_cnt=32, exc_cause=3; variant with md_done at md_cnt=32 -> RUN, exc_cause unchanged.
REQ-038 Reset: assert rst=0 mid MD_WAIT between clock edges -> all outputs 0 immediately, RUN after release.

Source files
------------

// File: rtl/i2d_pctl.sv
// Pipeline control for the I2D core: load-use interlock, branch flush,
// exception vectoring and the multi-cycle MUL/DIV wait with timeout.
module i2d_pctl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] id_rf_ra,
    input  logic [5:0] id_rf_rb,
    input  logic       id_rf_r,
    input  logic       ex_load,
    input  logic [5:0] ex_rd,
    input  logic       ex_br_taken,
    input  logic       id_swi,
    input  logic       id_err,
    input  logic       md_start,
    input  logic       md_done,
    output logic       if_stall,
    output logic       id_dis,
    output logic       flush,
    output logic [1:0] pc_sel,
    output logic [1:0] exc_cause,
    output logic       md_busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        EXC     = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    localparam logic [5:0] MD_TIMEOUT = 6'd32;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_VECTOR = 2'b10;

    localparam logic [1:0] CAUSE_SWI     = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    state_t     state_q, state_d;
    logic [5:0] md_cnt_q, md_cnt_d;
    logic [1:0] cause_q, cause_d;

    logic       load_use;
    logic       if_stall_c, id_dis_c, flush_c, md_busy_c;
    logic [1:0] pc_sel_c;

    assign load_use = ex_load & id_rf_r & (ex_rd != '0) &
                      ((ex_rd == id_rf_ra) | (ex_rd == id_rf_rb));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        md_cnt_d   = md_cnt_q;
        cause_d    = cause_q;
        if_stall_c = 1'b0;
        id_dis_c   = 1'b0;
        flush_c    = 1'b0;
        md_busy_c  = 1'b0;
        pc_sel_c   = PC_SEQ;

        unique case (state_q)
            RUN: begin
                if (id_swi | id_err) begin
                    state_d = EXC;
                    cause_d = id_err ? CAUSE_ILLEGAL : CAUSE_SWI;
                end else if (ex_br_taken) begin
                    pc_sel_c = PC_BRANCH;
                    state_d  = FLUSH;
                end else if (md_start) begin
                    state_d  = MD_WAIT;
                    md_cnt_d = '0;
                end else if (load_use) begin
                    if_stall_c = 1'b1;
                    id_dis_c   = 1'b1;
                end
            end
            MD_WAIT: begin
                if_stall_c = 1'b1;
                id_dis_c   = 1'b1;
                md_busy_c  = 1'b1;
                md_cnt_d   = md_cnt_q + 6'd1;
                // a result arriving on the timeout cycle still counts as done
                if (md_done) begin
                    state_d = RUN;
                end else if (md_cnt_q == MD_TIMEOUT) begin
                    state_d = EXC;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            EXC: begin
                pc_sel_c = PC_VECTOR;
                flush_c  = 1'b1;
                id_dis_c = 1'b1;
                state_d  = FLUSH;
            end
            FLUSH: begin
                flush_c  = 1'b1;
                id_dis_c = 1'b1;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign if_stall  = rst & if_stall_c;
    assign id_dis    = rst & id_dis_c;
    assign flush     = rst & flush_c;
    assign md_busy   = rst & md_busy_c;
    assign pc_sel    = rst ? pc_sel_c : PC_SEQ;
    assign exc_cause = cause_q;

endmodule
